// File: rtl/pwl_table_loader_if.sv
// Word stream into the PWL table loader: valid/ready handshake with a DW-bit payload.
// The producer drives valid/data; the loader answers with ready.
interface pwl_table_loader_if #(
    parameter int DW = 16
) ();
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pwl_table_loader.sv
// Writer side of the double-buffered PWL coefficient table: parses a framed stream,
// writes the inactive bank, and swaps banks only after the checksum matches.
module pwl_table_loader #(
    parameter int SEG       = 8,
    parameter int K_WIDTH_I = 4,
    parameter int K_WIDTH_F = 12,
    parameter int B_WIDTH_I = 4,
    parameter int B_WIDTH_F = 12,
    parameter int DW        = 16,
    parameter int AW        = $clog2(SEG),
    localparam int KW       = K_WIDTH_I + K_WIDTH_F,
    localparam int BW       = B_WIDTH_I + B_WIDTH_F
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    pwl_table_loader_if.slave    s,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 tbl_valid,
    input  logic [AW-1:0]        rd_addr,
    output logic signed [KW-1:0] rd_k,
    output logic signed [BW-1:0] rd_b
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_K,
        ST_B,
        ST_CSUM
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] seg;
    logic [DW-1:0] sum;
    logic          active;
    logic          accept;
    logic          hdr_ok;
    logic          csum_ok;
    logic          last_seg;

    // Bank b occupies entries {b, seg}; the active bank is only ever read.
    logic signed [KW-1:0] k_mem [2*SEG];
    logic signed [BW-1:0] b_mem [2*SEG];

    assign accept   = s.valid & s.ready;
    assign hdr_ok   = (s.data[DW-1 -: 8] == 8'hA5) && (s.data[7:0] == 8'(SEG));
    assign csum_ok  = (sum == s.data);
    assign last_seg = (seg == AW'(SEG - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)  state_d = ST_HDR;
            ST_HDR:  if (accept) state_d = hdr_ok ? ST_K : ST_IDLE;
            ST_K:    if (accept) state_d = ST_B;
            ST_B:    if (accept) state_d = last_seg ? ST_CSUM : ST_K;
            ST_CSUM: if (accept) state_d = ST_IDLE;
            default:             state_d = ST_IDLE;
        endcase
    end

    // ready depends on state only, so a producer may hold valid without a comb loop.
    always_comb begin
        s.ready = 1'b0;
        busy    = 1'b0;
        case (state_q)
            ST_HDR, ST_K, ST_B, ST_CSUM: begin
                s.ready = 1'b1;
                busy    = 1'b1;
            end
            default: begin
                s.ready = 1'b0;
                busy    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg       <= '0;
            sum       <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            tbl_valid <= 1'b0;
            active    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        sum <= '0;
                        seg <= '0;
                    end
                end
                ST_HDR: begin
                    if (accept && !hdr_ok) begin
                        err  <= 1'b1;
                        done <= 1'b1;
                    end
                end
                ST_K: begin
                    if (accept) sum <= sum + s.data;
                end
                ST_B: begin
                    if (accept) begin
                        sum <= sum + s.data;
                        if (!last_seg) seg <= seg + 1'b1;
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        done <= 1'b1;
                        if (csum_ok) begin
                            // Swap makes the freshly written bank visible in one edge.
                            err       <= 1'b0;
                            active    <= ~active;
                            tbl_valid <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the table RAM has no reset; tbl_valid alone says whether its
    // contents mean anything, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (state_q == ST_K && accept) begin
            k_mem[{~active, seg}] <= s.data[KW-1:0];
        end
        if (state_q == ST_B && accept) begin
            b_mem[{~active, seg}] <= s.data[BW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_k <= '0;
            rd_b <= '0;
        end else begin
            rd_k <= k_mem[{active, rd_addr}];
            rd_b <= b_mem[{active, rd_addr}];
        end
    end

endmodule

// File: tb/tb_pwl_table_loader.sv
// Self-checking bench for pwl_table_loader: directed frames plus randomized data,
// gaps and reads, checked against a table-level reference model.
module tb_pwl_table_loader;

    localparam int SEG = 8;
    localparam int DW  = 16;
    localparam int AW  = 3;
    localparam int KW  = 16;
    localparam int BW  = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic                 tbl_valid;
    logic [AW-1:0]        rd_addr;
    logic signed [KW-1:0] rd_k;
    logic signed [BW-1:0] rd_b;

    pwl_table_loader_if #(.DW(DW)) s_if ();

    pwl_table_loader #(.SEG(SEG), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s         (s_if),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .tbl_valid (tbl_valid),
        .rd_addr   (rd_addr),
        .rd_k      (rd_k),
        .rd_b      (rd_b)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the table the evaluator should see, and the load outcome.
    logic [15:0] m_k [SEG];
    logic [15:0] m_b [SEG];
    bit          m_valid = 0;
    bit          m_err   = 0;
    // Frame contents for the next load.
    logic [15:0] f_k [SEG];
    logic [15:0] f_b [SEG];
    // Expected read data for the read issued in the previous cycle.
    bit          rd_armed = 0;
    logic [15:0] exp_k;
    logic [15:0] exp_b;

    function automatic logic [15:0] frame_sum();
        logic [15:0] acc = 16'h0000;
        for (int i = 0; i < SEG; i++) acc = acc + f_k[i] + f_b[i];
        return acc;
    endfunction

    task automatic set_read(input int addr);
        rd_addr = AW'(addr);
        rd_armed = m_valid;
        exp_k = m_k[addr];
        exp_b = m_b[addr];
    endtask

    // Advance one cycle; land 1 time unit after the edge and check the pending read.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rd_armed) begin
            checks++;
            if (rd_k !== exp_k || rd_b !== exp_b) begin
                errors++;
                $display("FAIL rd_data: got k=%h b=%h, expected k=%h b=%h", rd_k, rd_b, exp_k, exp_b);
            end
        end
        rd_armed = 0;
    endtask

    // Start a load and stream one frame; checks handshake, done timing and outcome.
    task automatic run_frame(input string name, input logic [15:0] hdr, input logic [15:0] csum,
                             input int gap_pct, input bit mid_start, input int fixed_addr);
        logic [15:0] w[$];
        bit hdr_ok;
        bit pass;
        bit acc;
        int idx;
        int cyc;
        hdr_ok = (hdr[15:8] == 8'hA5) && (hdr[7:0] == 8'(SEG));
        pass   = hdr_ok && (csum == frame_sum());
        w.push_back(hdr);
        if (hdr_ok) begin
            for (int i = 0; i < SEG; i++) begin
                w.push_back(f_k[i]);
                w.push_back(f_b[i]);
            end
            w.push_back(csum);
        end

        start = 1'b1;
        set_read(fixed_addr >= 0 ? fixed_addr : int'($urandom_range(SEG - 1)));
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || s_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL %s start_response: busy=%b ready=%b, expected 1 1", name, busy, s_if.ready);
        end

        idx = 0;
        cyc = 0;
        while (idx < w.size() && cyc < 4000) begin
            s_if.valid = (gap_pct == 0) || ($urandom_range(99) >= gap_pct);
            s_if.data  = w[idx];
            start      = mid_start && (idx == w.size() / 2);
            checks++;
            if (done !== 1'b0 || s_if.ready !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s mid_frame: done=%b ready=%b busy=%b, expected 0 1 1",
                         name, done, s_if.ready, busy);
            end
            acc = s_if.valid && s_if.ready;
            set_read(fixed_addr >= 0 ? fixed_addr : int'($urandom_range(SEG - 1)));
            tick();
            if (acc) idx++;
            cyc++;
        end
        s_if.valid = 1'b0;
        start = 1'b0;
        if (idx < w.size()) begin
            errors++;
            $display("FAIL %s timeout: accepted %0d of %0d words", name, idx, w.size());
        end

        // This is the cycle after the final accepted word.
        if (pass) begin
            for (int i = 0; i < SEG; i++) begin
                m_k[i] = f_k[i];
                m_b[i] = f_b[i];
            end
            m_valid = 1;
            m_err   = 0;
        end else begin
            m_err = 1;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || s_if.ready !== 1'b0 || err !== m_err
            || tbl_valid !== m_valid) begin
            errors++;
            $display("FAIL %s end_of_load: done=%b busy=%b ready=%b err=%b tbl_valid=%b, expected 1 0 0 %b %b",
                     name, done, busy, s_if.ready, err, tbl_valid, m_err, m_valid);
        end
        set_read(fixed_addr >= 0 ? fixed_addr : int'($urandom_range(SEG - 1)));
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || err !== m_err) begin
            errors++;
            $display("FAIL %s after_done: done=%b busy=%b err=%b, expected 0 0 %b", name, done, busy, err, m_err);
        end
    endtask

    task automatic load_basic_frame();
        for (int i = 0; i < SEG; i++) begin
            f_k[i] = 16'(16'h0100 * i);
            f_b[i] = 16'(16'h0010 + i);
        end
    endtask

    task automatic read_expect(input string name, input int addr, input logic [15:0] k,
                               input logic [15:0] b);
        set_read(addr);
        tick();
        checks++;
        if (rd_k !== k || rd_b !== b) begin
            errors++;
            $display("FAIL %s: rd_addr=%0d got k=%h b=%h, expected k=%h b=%h", name, addr, rd_k, rd_b, k, b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        s_if.valid = 1'b0;
        s_if.data = '0;
        rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (s_if.ready !== 0 || busy !== 0 || done !== 0 || err !== 0 || tbl_valid !== 0
            || rd_k !== 0 || rd_b !== 0) begin
            errors++;
            $display("FAIL reset_values: ready=%b busy=%b done=%b err=%b tbl_valid=%b rd_k=%h rd_b=%h, expected all 0",
                     s_if.ready, busy, done, err, tbl_valid, rd_k, rd_b);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (s_if.ready !== 0 || busy !== 0 || done !== 0 || err !== 0 || tbl_valid !== 0) begin
            errors++;
            $display("FAIL idle_after_reset: ready=%b busy=%b done=%b err=%b tbl_valid=%b, expected all 0",
                     s_if.ready, busy, done, err, tbl_valid);
        end
    endtask

    task automatic test_basic_load();
        load_basic_frame();
        run_frame("basic", 16'hA508, 16'h1C9C, 0, 0, -1);
        read_expect("basic_read3", 3, 16'h0300, 16'h0013);
    endtask

    task automatic test_bad_header();
        run_frame("bad_header", 16'hA507, 16'h0000, 0, 0, -1);
        checks++;
        if (err !== 1'b1 || s_if.ready !== 1'b0 || tbl_valid !== 1'b1) begin
            errors++;
            $display("FAIL bad_header_status: err=%b ready=%b tbl_valid=%b, expected 1 0 1", err, s_if.ready, tbl_valid);
        end
        read_expect("bad_header_read3", 3, 16'h0300, 16'h0013);
    endtask

    task automatic test_bad_checksum();
        logic [15:0] good;
        for (int i = 0; i < SEG; i++) begin
            f_k[i] = 16'hFFFF;
            f_b[i] = 16'h0001;
        end
        good = frame_sum();
        run_frame("bad_csum", 16'hA508, good ^ 16'h0001, 0, 0, -1);
        checks++;
        if (err !== 1'b1 || tbl_valid !== 1'b1) begin
            errors++;
            $display("FAIL bad_csum_status: err=%b tbl_valid=%b, expected 1 1", err, tbl_valid);
        end
        read_expect("bad_csum_read5", 5, 16'h0500, 16'h0015);
        run_frame("good_csum", 16'hA508, good, 0, 0, -1);
        read_expect("good_csum_read5", 5, 16'hFFFF, 16'h0001);
    endtask

    task automatic test_backpressure();
        load_basic_frame();
        run_frame("backpressure", 16'hA508, 16'h1C9C, 50, 1, -1);
        for (int i = 0; i < SEG; i++) begin
            read_expect("backpressure_table", i, 16'(16'h0100 * i), 16'(16'h0010 + i));
        end
    endtask

    task automatic test_reset_mid_load();
        logic [15:0] w [5];
        load_basic_frame();
        w = '{16'hA508, f_k[0], f_b[0], f_k[1], f_b[1]};
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_if.valid = 1'b1;
            s_if.data  = w[i];
            tick();
        end
        s_if.valid = 1'b0;
        rst = 1'b1;
        #1;
        m_valid = 0;
        m_err   = 0;
        checks++;
        if (s_if.ready !== 0 || busy !== 0 || done !== 0 || err !== 0 || tbl_valid !== 0
            || rd_k !== 0 || rd_b !== 0) begin
            errors++;
            $display("FAIL reset_mid_load: ready=%b busy=%b done=%b err=%b tbl_valid=%b rd_k=%h rd_b=%h, expected all 0",
                     s_if.ready, busy, done, err, tbl_valid, rd_k, rd_b);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (done !== 0 || busy !== 0 || tbl_valid !== 0) begin
                errors++;
                $display("FAIL post_reset_idle: done=%b busy=%b tbl_valid=%b, expected 0 0 0", done, busy, tbl_valid);
            end
        end
        run_frame("reload_after_reset", 16'hA508, 16'h1C9C, 0, 0, -1);
    endtask

    task automatic test_read_swap();
        load_basic_frame();
        f_k[0] = 16'h0ABC;
        read_expect("swap_before", 0, 16'h0000, 16'h0010);
        run_frame("read_swap", 16'hA508, frame_sum(), 0, 0, 0);
        read_expect("swap_after", 0, 16'h0ABC, 16'h0010);
    endtask

    task automatic test_random_frames();
        logic [15:0] hdr;
        logic [15:0] csum;
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < SEG; i++) begin
                f_k[i] = 16'($urandom);
                f_b[i] = 16'($urandom);
            end
            hdr  = ($urandom_range(3) == 0) ? (16'hA508 ^ (16'h0001 << $urandom_range(15))) : 16'hA508;
            csum = ($urandom_range(2) == 0) ? (frame_sum() + 16'($urandom_range(1, 65535))) : frame_sum();
            run_frame("random", hdr, csum, int'($urandom_range(60)), $urandom_range(1) == 1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_bad_header();
        test_bad_checksum();
        test_backpressure();
        test_reset_mid_load();
        test_read_swap();
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
